// File: rtl/mdu_seq_pkg.sv
// ============================================================================
//  Module      : mdu_seq_pkg
//  Description : Shared encodings for the iterative multiply/divide sequencer
//                (operation codes, FSM states, HI/LO bus width).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_seq_pkg;

    // Operation encodings as issued by EX
    localparam logic [1:0] MDU_OP_MULT  = 2'b00;
    localparam logic [1:0] MDU_OP_MULTU = 2'b01;
    localparam logic [1:0] MDU_OP_DIV   = 2'b10;
    localparam logic [1:0] MDU_OP_DIVU  = 2'b11;

    // Width of the {hi_we, lo_we, hi, lo} forwarding bus
    localparam int HILO_BUS_WD = 66;

    // Sequencer states
    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_MUL  = 2'd1,
        MDU_ST_DIV  = 2'd2,
        MDU_ST_DONE = 2'd3
    } mdu_state_t;

    // Even op codes (mult, div) treat operands as two's complement
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_sign_fix.sv
// ============================================================================
//  Module      : mdu_sign_fix
//  Description : Combinational conditional two's-complement negate. Used for
//                operand magnitudes and for result sign correction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_val,
    input  logic         neg,
    output logic [W-1:0] out_val
);

    // Negate when requested; the most negative value maps onto itself
    assign out_val = neg ? (~in_val + W'(1)) : in_val;

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// ============================================================================
//  Module      : mdu_seq
//  Description : Iterative multiply/divide sequencer owning the HI/LO write
//                path. Shift-add multiply and restoring divide, one bit per
//                cycle, on unsigned magnitudes with sign correction at the end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_W-1:0]     src_a,
    input  logic [DATA_W-1:0]     src_b,
    input  logic                  cancel,
    output logic                  stall_req,
    output logic                  busy,
    output logic                  div_zero,
    output logic                  hi_we,
    output logic                  lo_we,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic [2*DATA_W+1:0]   hilo_bus
);

    mdu_state_t state, state_nx;

    // Accumulator: MUL holds {partial product, remaining multiplier};
    // DIV holds {partial remainder, remaining dividend / quotient bits}.
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   mag_op;     // multiplicand (MUL) or divisor (DIV) magnitude
    logic [CNT_W-1:0]    cnt;
    logic                neg_res;    // product / quotient must be negated
    logic                neg_rem;    // remainder takes the dividend's sign
    logic                is_div;
    logic                dz;         // divisor was zero

    logic                sgn, neg_a, neg_b, accept, b_zero, last, we;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift, div_trial;
    logic                div_ok;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix, hi_res, lo_res;

    assign sgn    = op_is_signed(op);
    assign neg_a  = sgn & src_a[DATA_W-1];
    assign neg_b  = sgn & src_b[DATA_W-1];
    assign accept = (state == MDU_ST_IDLE) & start & ~cancel;
    assign b_zero = (src_b == '0);
    assign last   = (cnt == CNT_W'(DATA_W-1));

    mdu_sign_fix #(.W(DATA_W)) u_abs_a (.in_val(src_a), .neg(neg_a), .out_val(abs_a));
    mdu_sign_fix #(.W(DATA_W)) u_abs_b (.in_val(src_b), .neg(neg_b), .out_val(abs_b));

    // One multiply step: add multiplicand if the current multiplier bit is set
    assign mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} +
                     {1'b0, mag_op & {DATA_W{acc[0]}}};

    // One restoring divide step: shift in next dividend bit, trial-subtract divisor
    assign div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign div_trial = div_shift - {1'b0, mag_op};
    assign div_ok    = ~div_trial[DATA_W];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MDU_ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        stall_req = 1'b0;
        we        = 1'b0;
        case (state)
            MDU_ST_IDLE: begin
                if (accept) begin
                    stall_req = 1'b1;
                    if (op[1] && b_zero) state_nx = MDU_ST_DONE;
                    else if (op[1])      state_nx = MDU_ST_DIV;
                    else                 state_nx = MDU_ST_MUL;
                end
            end
            MDU_ST_MUL, MDU_ST_DIV: begin
                stall_req = ~cancel;
                if (cancel)    state_nx = MDU_ST_IDLE;
                else if (last) state_nx = MDU_ST_DONE;
            end
            MDU_ST_DONE: begin
                we       = ~cancel;
                state_nx = MDU_ST_IDLE;
            end
            default: state_nx = MDU_ST_IDLE;
        endcase
    end

    // Operand capture and iterative datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mag_op  <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            is_div  <= 1'b0;
            dz      <= 1'b0;
        end else begin
            case (state)
                MDU_ST_IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        neg_res <= neg_a ^ neg_b;
                        neg_rem <= neg_a;
                        is_div  <= op[1];
                        dz      <= op[1] & b_zero;
                        mag_op  <= op[1] ? abs_b : abs_a;
                        if (op[1] && b_zero)
                            acc <= {src_a, {DATA_W{1'b1}}};
                        else if (op[1])
                            acc <= {{DATA_W{1'b0}}, abs_a};
                        else
                            acc <= {{DATA_W{1'b0}}, abs_b};
                    end
                end
                MDU_ST_MUL: begin
                    acc <= {mul_sum, acc[DATA_W-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                MDU_ST_DIV: begin
                    acc <= {(div_ok ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                            acc[DATA_W-2:0], div_ok};
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    mdu_sign_fix #(.W(2*DATA_W)) u_fix_prod (.in_val(acc), .neg(neg_res), .out_val(prod_fix));
    mdu_sign_fix #(.W(DATA_W)) u_fix_quo (.in_val(acc[DATA_W-1:0]), .neg(neg_res), .out_val(quo_fix));
    mdu_sign_fix #(.W(DATA_W)) u_fix_rem (.in_val(acc[2*DATA_W-1:DATA_W]), .neg(neg_rem), .out_val(rem_fix));

    // Final result selection; divide-by-zero values bypass sign correction
    always_comb begin
        hi_res = prod_fix[2*DATA_W-1:DATA_W];
        lo_res = prod_fix[DATA_W-1:0];
        if (dz) begin
            hi_res = acc[2*DATA_W-1:DATA_W];
            lo_res = acc[DATA_W-1:0];
        end else if (is_div) begin
            hi_res = rem_fix;
            lo_res = quo_fix;
        end
    end

    assign busy     = (state != MDU_ST_IDLE);
    assign hi_we    = we;
    assign lo_we    = we;
    assign div_zero = we & dz;
    assign hi_o     = we ? hi_res : '0;
    assign lo_o     = we ? lo_res : '0;
    assign hilo_bus = {hi_we, lo_we, hi_o, lo_o};

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// ============================================================================
//  Module      : tb_mdu_seq
//  Description : Self-checking bench for mdu_seq with a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_seq;
    import mdu_seq_pkg::*;

    localparam int DW = 32;

    logic          clk, rst, start, cancel;
    logic [1:0]    op;
    logic [DW-1:0] src_a, src_b;
    logic          stall_req, busy, div_zero, hi_we, lo_we;
    logic [DW-1:0] hi_o, lo_o;
    logic [2*DW+1:0] hilo_bus;

    typedef struct {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic          dz;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t mon_e;
    int n_tests = 0;
    int n_fail  = 0;

    mdu_seq #(.DATA_W(DW), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .stall_req(stall_req), .busy(busy), .div_zero(div_zero),
        .hi_we(hi_we), .lo_we(lo_we), .hi_o(hi_o), .lo_o(lo_o), .hilo_bus(hilo_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [66:0] got, input logic [66:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: {dz, hi, lo} from language arithmetic
    function automatic logic [64:0] model(input logic [1:0] mop, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        logic [63:0] p;
        int sa, sb_, q, r;
        sa = int'($signed(a));
        sb_ = int'($signed(b));
        case (mop)
            MDU_OP_MULT: begin
                p = 64'(longint'(sa) * longint'(sb_));
                return {1'b0, p};
            end
            MDU_OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            MDU_OP_DIV: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
                q = sa / sb_;
                r = sa % sb_;
                return {1'b0, 32'(r), 32'(q)};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Output monitor: every write pops one scoreboard entry; otherwise the bus must be idle
    always @(negedge clk) begin
        if (hi_we | lo_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {1'b0, hilo_bus}, 67'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("hilo_bus", {1'b0, hilo_bus}, {1'b0, 2'b11, mon_e.hi, mon_e.lo});
                chk("div_zero", {66'd0, div_zero}, {66'd0, mon_e.dz});
            end
        end else begin
            chk("idle_bus", {div_zero, hilo_bus}, 67'd0);
        end
    end

    // Issue one op, push its expected result, and check latency and stall length.
    // A start pulse is also driven while busy; it must be ignored.
    task automatic run_op(input logic [1:0] mop, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo,
                          input logic exp_dz, input int exp_lat);
        sb_entry_t e;
        int lat = 999;
        int stalls = 0;
        @(posedge clk); #1;
        start = 1'b1; op = mop; src_a = a; src_b = b;
        e.hi = exp_hi; e.lo = exp_lo; e.dz = exp_dz;
        sb.push_back(e);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            if (hi_we) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
            start = (c == 4);
            if (c == 4) begin
                op = MDU_OP_DIVU; src_b = '0;
            end
        end
        start = 1'b0;
        chk("latency", 67'(lat), 67'(exp_lat));
        chk("stall_cycles", 67'(stalls), 67'(exp_lat));
    endtask

    task automatic run_model(input logic [1:0] mop, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [64:0] m;
        m = model(mop, a, b);
        run_op(mop, a, b, m[63:32], m[31:0], m[64], (mop[1] && b == 0) ? 1 : DW + 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {66'd0, busy}, 67'd0);
        chk("rst_stall", {66'd0, stall_req}, 67'd0);
        chk("rst_bus",   {1'b0, hilo_bus}, 67'd0);
        rst = 1'b0;

        // Directed vectors
        run_op(MDU_OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
        run_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33);
        run_op(MDU_OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        run_op(MDU_OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 33);
        run_op(MDU_OP_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1);
        run_op(MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33);

        // Cancel at cycle 10 of a divide: no write may ever appear
        @(posedge clk); #1;
        start = 1'b1; op = MDU_OP_DIV; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(negedge clk);
        chk("cancel_stall", {66'd0, stall_req}, 67'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", {66'd0, busy}, 67'd0);
        repeat (40) @(negedge clk);
        run_op(MDU_OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 33);

        // Reset at cycle 20 of a multiply
        @(posedge clk); #1;
        start = 1'b1; op = MDU_OP_MULT; src_a = 32'h1234; src_b = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_busy",  {66'd0, busy}, 67'd0);
        chk("rst_mid_stall", {66'd0, stall_req}, 67'd0);
        chk("rst_mid_bus",   {1'b0, hilo_bus}, 67'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_busy", {66'd0, busy}, 67'd0);
        repeat (40) @(negedge clk);

        // Random operands against the reference model
        for (int i = 0; i < 8; i++) begin
            run_model(2'($urandom_range(0, 3)), $urandom, (i == 3) ? 32'd0 : $urandom);
        end
        run_model(MDU_OP_DIV,  32'h8000_0000, 32'd7);
        run_model(MDU_OP_MULT, 32'h8000_0000, 32'h8000_0000);

        repeat (3) @(negedge clk);
        chk("sb_empty", 67'(sb.size()), 67'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
